pemstat_rdctl: RTL and testbench
================================

PEMSTAT_RDCTL -- requirements
Module: pemstat_rdctl

Interface
REQ-001 SHALL have parameter NUM_CNT, default 8, number of attached statistics counters (1..28).
REQ-002 SHALL have parameter CNT_W, default 31, width of each counter value word.
REQ-003 SHALL have ports: clk  in  1  single clock; rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: req  in  1  host request (4-phase); wr  in  1  1=write, 0=read; addr  in  5  register address; wdata  in  32  write data.
REQ-005 SHALL have ports: ack  out  1  request complete; rdata  out  32  read data, valid while ack=1.
REQ-006 SHALL have ports: cnt_val  in  NUM_CNT*CNT_W  counter values (counter i at bits [i*CNT_W +: CNT_W]); cnt_ovf  in  NUM_CNT  per-counter sticky overflow flags.
REQ-007 SHALL have ports: cnt_clr  out  NUM_CNT  one-cycle counter clear; cnt_ovf_clr  out  NUM_CNT  one-cycle overflow-flag clear; cnt_ld  out  NUM_CNT  one-cycle load strobe; cnt_ld_data  out  CNT_W  load value.
REQ-008 SHALL have port irq  out  1  registered interrupt, unmasked carry pending.

Function
REQ-009 SHALL use address map: 0..NUM_CNT-1 counters; 0x1C carry (W1C); 0x1D carry mask; 0x1E control (bit0 rdclr); 0x1F clear-all (write-only, returns 0).
REQ-010 SHALL implement FSM IDLE->CAPT->ACT->ACK->IDLE; leave IDLE only when req=1; leave ACK only when req=0.
REQ-011 SHALL, in CAPT, register rdata from the addressed source, zero-extended to 32 bits; unmapped or write-only addresses read 0.
REQ-012 SHALL, in ACT, pulse exactly one strobe for one cycle: read of counter i with rdclr=1 -> cnt_clr[i]; write to counter i -> cnt_ld[i] with cnt_ld_data=wdata[CNT_W-1:0]; write 0x1F -> all cnt_clr and all cnt_ovf_clr bits.
REQ-013 SHALL assert ack from ACK entry until req deasserts; read-to-ack latency is exactly 3 cycles after req sampled high.
REQ-014 SHALL hold rdata stable while ack=1, even if cnt_val changes.
REQ-015 SHALL set carry[i] on any cycle with cnt_ovf[i]=1.
REQ-016 SHALL, on a write to 0x1C in ACT, clear carry[i] and pulse cnt_ovf_clr[i] for each wdata[i]=1; clear wins over a simultaneous set that cycle.
REQ-017 SHALL drive irq one cycle after any carry[i]&~mask[i] becomes set; irq drops one cycle after no such bit remains.
REQ-018 SHALL ignore writes to bits above NUM_CNT in carry and mask, and bits above 0 in control.
REQ-019 SHALL keep all strobe outputs low outside ACT.

Reset
REQ-020 SHALL, on rst=1 at a clock edge, go to IDLE with ack=0, rdata=0, carry=0, mask=all-ones, rdclr=0, irq=0, all strobes 0.
REQ-021 SHALL abort an in-flight transaction on rst mid-operation with no strobe issued; the host re-requests.

Configuration
REQ-022 SHALL recognise macro PEMSTAT_RDCLR_EN: defined -> control bit0 writable, REQ-012 read-clear active; undefined -> rdclr reads 0, writes ignored, cnt_clr only from clear-all.

Structure
REQ-023 SHALL take address constants, FSM state encoding and default parameter values from shared package pemstat_pkg.
REQ-024 SHALL place carry/mask/irq logic in sub-module pemstat_carry; the FSM and read mux stay in the top module.

Verification
REQ-025 Bench SHALL cover: cnt_val[3]=0x123, read addr 3 -> rdata=0x00000123, ack 3 cycles after req, held until req low.
REQ-026 Bench SHALL cover: rdclr=1 (macro defined), read addr 2 -> cnt_clr=0x04 for exactly one cycle in ACT; macro undefined -> no pulse, control reads 0.
REQ-027 Bench SHALL cover: cnt_ovf[5] rises, mask=0xDF -> irq=1 next cycle; write 0x1C wdata=0x20 -> cnt_ovf_clr=0x20 one cycle, carry=0, irq=0 one cycle later.
REQ-028 Bench SHALL cover: write addr 1 wdata=0xFFF -> cnt_ld=0x02, cnt_ld_data=0xFFF for one cycle.
REQ-029 Bench SHALL cover: write 0x1F -> cnt_clr=0xFF and cnt_ovf_clr=0xFF in one cycle; read 0x1F -> 0.
REQ-030 Bench SHALL cover: rst asserted during CAPT -> next cycle IDLE, ack=0, no strobe; read addr 0x1B -> rdata=0 with normal ack.

Source files
------------

// File: rtl/pemstat_pkg.sv
// ---------------------------------------------------------------------------
// pemstat_pkg
// Shared definitions for the statistics-counter read/control block:
//   - default parameter values for the counter bank
//   - register address map of the host-visible space
//   - FSM state encoding of the host transaction sequencer
// ---------------------------------------------------------------------------
package pemstat_pkg;

    localparam int NUM_CNT_DEF = 8;
    localparam int CNT_W_DEF   = 31;

    // Counters occupy addresses 0..NUM_CNT-1; the control registers sit at the top.
    localparam logic [4:0] ADDR_CARRY  = 5'h1C;
    localparam logic [4:0] ADDR_MASK   = 5'h1D;
    localparam logic [4:0] ADDR_CTRL   = 5'h1E;
    localparam logic [4:0] ADDR_CLRALL = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_ACT  = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

endpackage

// File: rtl/pemstat_rdctl_if.sv
// ---------------------------------------------------------------------------
// pemstat_rdctl_if
// Host register-access bus (4-phase req/ack handshake).
//   req   : host request, held high until ack is seen, then dropped
//   wr    : 1 = write, 0 = read
//   addr  : 5-bit register address
//   wdata : 32-bit write data
//   ack   : transaction complete, held until req drops
//   rdata : 32-bit read data, valid while ack = 1
// Modports: master (host side), slave (pemstat_rdctl side).
// ---------------------------------------------------------------------------
interface pemstat_rdctl_if;

    logic        req;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, wr, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, wr, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/pemstat_carry.sv
// ---------------------------------------------------------------------------
// pemstat_carry
// Sticky carry (overflow-seen) register, its interrupt mask and the
// registered interrupt output.
//   clk, rst    : clock, synchronous active-high reset
//   cnt_ovf     : per-counter overflow flags; any high cycle sets carry[i]
//   carry_clr   : write-1-to-clear vector, valid for one cycle
//   mask_we     : mask register write enable (one cycle)
//   mask_wdata  : new mask value
//   carry, mask : current register contents (for host readback)
//   irq         : registered OR of unmasked carry bits
// ---------------------------------------------------------------------------
module pemstat_carry
    import pemstat_pkg::*;
#(
    parameter int NUM_CNT = NUM_CNT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CNT-1:0] cnt_ovf,
    input  logic [NUM_CNT-1:0] carry_clr,
    input  logic               mask_we,
    input  logic [NUM_CNT-1:0] mask_wdata,
    output logic [NUM_CNT-1:0] carry,
    output logic [NUM_CNT-1:0] mask,
    output logic               irq
);

    logic [NUM_CNT-1:0] carry_q, carry_d;
    logic [NUM_CNT-1:0] mask_q, mask_d;
    logic               irq_q, irq_d;

    always_comb begin
        // Clear is applied after the set so a host clear beats a same-cycle overflow.
        carry_d = (carry_q | cnt_ovf) & ~carry_clr;
        mask_d  = mask_we ? mask_wdata : mask_q;
        // Evaluated from the registered carry, so irq trails a new carry bit by one cycle.
        irq_d   = |(carry_q & ~mask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= '0;
            mask_q  <= '1;
            irq_q   <= 1'b0;
        end else begin
            carry_q <= carry_d;
            mask_q  <= mask_d;
            irq_q   <= irq_d;
        end
    end

    assign carry = carry_q;
    assign mask  = mask_q;
    assign irq   = irq_q;

endmodule

// File: rtl/pemstat_rdctl.sv
// ---------------------------------------------------------------------------
// pemstat_rdctl
// Host register front-end for a bank of statistics counters.
// A request walks IDLE -> CAPT -> ACT -> ACK -> IDLE:
//   CAPT : read data registered from the addressed source
//   ACT  : exactly one strobe set pulses; register writes take effect
//   ACK  : ack held until the host drops req
// Ports:
//   clk, rst     : clock, synchronous active-high reset (aborts a transaction)
//   host         : pemstat_rdctl_if.slave host bus
//   cnt_val      : counter values, counter i at [i*CNT_W +: CNT_W]
//   cnt_ovf      : per-counter sticky overflow flags
//   cnt_clr      : one-cycle counter clear strobes
//   cnt_ovf_clr  : one-cycle overflow-flag clear strobes
//   cnt_ld       : one-cycle counter load strobes
//   cnt_ld_data  : load value, valid with cnt_ld
//   irq          : registered interrupt, unmasked carry pending
// Build option: define PEMSTAT_RDCLR_EN to enable the read-clear control bit
// (control bit0). Without it the bit reads 0 and counters clear only through
// the clear-all register.
// ---------------------------------------------------------------------------
module pemstat_rdctl
    import pemstat_pkg::*;
#(
    parameter int NUM_CNT = NUM_CNT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    pemstat_rdctl_if.slave           host,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_val,
    input  logic [NUM_CNT-1:0]       cnt_ovf,
    output logic [NUM_CNT-1:0]       cnt_clr,
    output logic [NUM_CNT-1:0]       cnt_ovf_clr,
    output logic [NUM_CNT-1:0]       cnt_ld,
    output logic [CNT_W-1:0]         cnt_ld_data,
    output logic                     irq
);

    state_t             state_q, state_d;
    logic               ack_q, ack_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               wr_q, wr_d;
    logic [4:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [NUM_CNT-1:0] clr_q, clr_d;
    logic [NUM_CNT-1:0] oclr_q, oclr_d;
    logic [NUM_CNT-1:0] ld_q, ld_d;
    logic [CNT_W-1:0]   ld_data_q, ld_data_d;

    logic [NUM_CNT-1:0] cnt_sel;
    logic               cnt_hit;
    logic [31:0]        rd_mux;
    logic               act_wr;
    logic [NUM_CNT-1:0] carry_clr;
    logic               mask_we;
    logic [NUM_CNT-1:0] carry;
    logic [NUM_CNT-1:0] mask;
    logic               rdclr;

    // wdata bit 31 has no destination when CNT_W < 32.
    logic               unused_wdata_msb;
    assign unused_wdata_msb = wdata_q[31];

    // Register side effects land at the end of ACT, the same cycle the strobes are visible.
    assign act_wr    = (state_q == ST_ACT) && wr_q;
    assign carry_clr = (act_wr && addr_q == ADDR_CARRY) ? wdata_q[NUM_CNT-1:0] : '0;
    assign mask_we   = act_wr && (addr_q == ADDR_MASK);

`ifdef PEMSTAT_RDCLR_EN
    logic rdclr_q, rdclr_d;

    always_comb begin
        rdclr_d = (act_wr && addr_q == ADDR_CTRL) ? wdata_q[0] : rdclr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdclr_q <= 1'b0;
        end else begin
            rdclr_q <= rdclr_d;
        end
    end

    assign rdclr = rdclr_q;
`else
    assign rdclr = 1'b0;
`endif

    pemstat_carry #(
        .NUM_CNT (NUM_CNT)
    ) u_carry (
        .clk        (clk),
        .rst        (rst),
        .cnt_ovf    (cnt_ovf),
        .carry_clr  (carry_clr),
        .mask_we    (mask_we),
        .mask_wdata (wdata_q[NUM_CNT-1:0]),
        .carry      (carry),
        .mask       (mask),
        .irq        (irq)
    );

    // Address decode and read mux work on the request captured at IDLE exit.
    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_sel[i] = (addr_q == 5'(i));
        end
        cnt_hit = |cnt_sel;

        rd_mux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (cnt_sel[i]) begin
                rd_mux[CNT_W-1:0] = cnt_val[i*CNT_W +: CNT_W];
            end
        end
        case (addr_q)
            ADDR_CARRY: rd_mux[NUM_CNT-1:0] = carry;
            ADDR_MASK:  rd_mux[NUM_CNT-1:0] = mask;
            ADDR_CTRL:  rd_mux[0]           = rdclr;
            default:    ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        clr_d     = '0;
        oclr_d    = '0;
        ld_d      = '0;
        ld_data_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (host.req) begin
                    state_d = ST_CAPT;
                    wr_d    = host.wr;
                    addr_d  = host.addr;
                    wdata_d = host.wdata;
                end
            end
            ST_CAPT: begin
                state_d = ST_ACT;
                rdata_d = rd_mux;
                // Strobes are registered here so they are high for the ACT cycle only.
                if (wr_q) begin
                    if (cnt_hit) begin
                        ld_d      = cnt_sel;
                        ld_data_d = wdata_q[CNT_W-1:0];
                    end else if (addr_q == ADDR_CARRY) begin
                        oclr_d = wdata_q[NUM_CNT-1:0];
                    end else if (addr_q == ADDR_CLRALL) begin
                        clr_d  = '1;
                        oclr_d = '1;
                    end
                end else if (cnt_hit && rdclr) begin
                    clr_d = cnt_sel;
                end
            end
            ST_ACT: begin
                state_d = ST_ACK;
                ack_d   = 1'b1;
            end
            ST_ACK: begin
                if (!host.req) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Control and host-visible outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            clr_q   <= '0;
            oclr_q  <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            clr_q   <= clr_d;
            oclr_q  <= oclr_d;
            ld_q    <= ld_d;
        end
    end

    // Captured request fields and load data are only consumed under state qualification.
    always_ff @(posedge clk) begin
        wr_q      <= wr_d;
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        ld_data_q <= ld_data_d;
    end

    assign host.ack    = ack_q;
    assign host.rdata  = rdata_q;
    assign cnt_clr     = clr_q;
    assign cnt_ovf_clr = oclr_q;
    assign cnt_ld      = ld_q;
    assign cnt_ld_data = ld_data_q;

endmodule

// File: tb/tb_pemstat_rdctl.sv
// ---------------------------------------------------------------------------
// tb_pemstat_rdctl
// Self-checking bench for pemstat_rdctl (NUM_CNT=8, CNT_W=31).
// Directed table of host transactions, hand-written carry/irq and reset
// sequences, then randomized transactions checked against a register-level
// reference model. Works with or without PEMSTAT_RDCLR_EN defined.
// ---------------------------------------------------------------------------
module tb_pemstat_rdctl;

    localparam int N = 8;
    localparam int W = 31;

`ifdef PEMSTAT_RDCLR_EN
    localparam bit RDCLR = 1'b1;
`else
    localparam bit RDCLR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   cnt_val;
    logic [N-1:0]     cnt_ovf;
    logic [N-1:0]     cnt_clr;
    logic [N-1:0]     cnt_ovf_clr;
    logic [N-1:0]     cnt_ld;
    logic [W-1:0]     cnt_ld_data;
    logic             irq;

    always #5 clk = ~clk;

    pemstat_rdctl_if bus ();

    pemstat_rdctl #(
        .NUM_CNT (N),
        .CNT_W   (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (bus),
        .cnt_val     (cnt_val),
        .cnt_ovf     (cnt_ovf),
        .cnt_clr     (cnt_clr),
        .cnt_ovf_clr (cnt_ovf_clr),
        .cnt_ld      (cnt_ld),
        .cnt_ld_data (cnt_ld_data),
        .irq         (irq)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: register contents and counter values.
    logic [W-1:0] cv [N];
    logic [N-1:0] m_carry;
    logic [N-1:0] m_mask;
    logic         m_rdclr;

    typedef struct {
        int          lat;
        logic [31:0] rd;
        logic        hold_ok;
        int          clr_n;
        logic [7:0]  clr_v;
        int          oclr_n;
        logic [7:0]  oclr_v;
        int          ld_n;
        logic [7:0]  ld_v;
        logic [30:0] ldd_v;
        logic        irq_ack;
        logic        irq_post;
    } obs_t;

    typedef struct {
        string       name;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_clr;
        logic [7:0]  exp_oclr;
        logic [7:0]  exp_ld;
        logic [30:0] exp_ldd;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_cv();
        for (int i = 0; i < N; i++) cnt_val[i*W +: W] = cv[i];
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (int'(a) < N) return 32'(cv[a[2:0]]);
        case (a)
            5'h1C:   return 32'(m_carry);
            5'h1D:   return 32'(m_mask);
            5'h1E:   return 32'(m_rdclr);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_strobes(input logic w, input logic [4:0] a, input logic [31:0] wd,
                                 output logic [7:0] clr, output logic [7:0] oclr,
                                 output logic [7:0] ld, output logic [30:0] ldd);
        clr = 8'h0; oclr = 8'h0; ld = 8'h0; ldd = 31'h0;
        if (w) begin
            if (int'(a) < N) begin
                ld  = 8'(1) << a[2:0];
                ldd = wd[30:0];
            end else if (a == 5'h1C) begin
                oclr = wd[7:0];
            end else if (a == 5'h1F) begin
                clr  = 8'hFF;
                oclr = 8'hFF;
            end
        end else if (int'(a) < N && m_rdclr) begin
            clr = 8'(1) << a[2:0];
        end
    endtask

    task automatic model_apply(input logic w, input logic [4:0] a, input logic [31:0] wd);
        if (w) begin
            case (a)
                5'h1C: m_carry = m_carry & ~wd[7:0];
                5'h1D: m_mask  = wd[7:0];
                5'h1E: if (RDCLR) m_rdclr = wd[0];
                default: ;
            endcase
        end
    endtask

    task automatic sample(inout obs_t o);
        if (cnt_clr != 8'h0) begin o.clr_n++; o.clr_v = o.clr_v | cnt_clr; end
        if (cnt_ovf_clr != 8'h0) begin o.oclr_n++; o.oclr_v = o.oclr_v | cnt_ovf_clr; end
        if (cnt_ld != 8'h0) begin o.ld_n++; o.ld_v = o.ld_v | cnt_ld; o.ldd_v = cnt_ld_data; end
    endtask

    // One full 4-phase transaction; records latency, held data and all strobe activity.
    task automatic txn(input logic w, input logic [4:0] a, input logic [31:0] wd, output obs_t o);
        o = '{default: 0};
        @(posedge clk); #1;
        bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = wd;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            sample(o);
            if (bus.ack) begin o.lat = k; break; end
        end
        o.rd      = bus.rdata;
        o.irq_ack = irq;
        o.hold_ok = 1'b1;
        cnt_val = ~cnt_val;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            sample(o);
            if (k == 0) o.irq_post = irq;
            if (!bus.ack || bus.rdata !== o.rd) o.hold_ok = 1'b0;
        end
        drive_cv();
        bus.req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            sample(o);
            if (!bus.ack) break;
        end
        if (bus.ack) o.hold_ok = 1'b0;
    endtask

    task automatic check_txn(input string nm, input obs_t o, input logic chk_rd, input logic [31:0] exp_rd,
                             input logic [7:0] e_clr, input logic [7:0] e_oclr,
                             input logic [7:0] e_ld, input logic [30:0] e_ldd);
        chk({nm, ".latency"}, 32'(o.lat), 32'd3);
        chk({nm, ".ack_hold"}, 32'(o.hold_ok), 32'd1);
        if (chk_rd) chk({nm, ".rdata"}, o.rd, exp_rd);
        chk({nm, ".cnt_clr"}, 32'(o.clr_v), 32'(e_clr));
        chk({nm, ".cnt_clr_cycles"}, 32'(o.clr_n), (e_clr != 8'h0) ? 32'd1 : 32'd0);
        chk({nm, ".cnt_ovf_clr"}, 32'(o.oclr_v), 32'(e_oclr));
        chk({nm, ".cnt_ovf_clr_cycles"}, 32'(o.oclr_n), (e_oclr != 8'h0) ? 32'd1 : 32'd0);
        chk({nm, ".cnt_ld"}, 32'(o.ld_v), 32'(e_ld));
        chk({nm, ".cnt_ld_cycles"}, 32'(o.ld_n), (e_ld != 8'h0) ? 32'd1 : 32'd0);
        if (e_ld != 8'h0) chk({nm, ".cnt_ld_data"}, 32'(o.ldd_v), 32'(e_ldd));
    endtask

    task automatic model_reset();
        m_carry = 8'h00;
        m_mask  = 8'hFF;
        m_rdclr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t        o;
        logic [7:0]  e_clr, e_oclr, e_ld;
        logic [30:0] e_ldd;
        logic [31:0] e_rd;
        logic        w;
        logic [4:0]  a;
        logic [31:0] wd;
        logic [7:0]  ov;
        int          r;
        int          strobe_seen;

        rst = 1'b1;
        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = 5'h0; bus.wdata = 32'h0;
        cnt_ovf = 8'h0;
        cv[0] = 31'h7FFFFFFF; cv[1] = 31'h1;      cv[2] = 31'h2AB;    cv[3] = 31'h123;
        cv[4] = 31'h40000000; cv[5] = 31'h5555;   cv[6] = 31'h0;      cv[7] = 31'h0ABCDEF;
        drive_cv();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.ack", 32'(bus.ack), 32'd0);
        chk("reset.rdata", bus.rdata, 32'h0);
        chk("reset.irq", 32'(irq), 32'd0);
        chk("reset.strobes", 32'({cnt_clr, cnt_ovf_clr, cnt_ld}), 32'h0);
        rst = 1'b0;

        // ---------------- directed table ----------------
        tbl.push_back('{"rd_cnt3",       1'b0, 5'h03, 32'h0,        1'b1, 32'h00000123, 8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"rd_cnt0_max",   1'b0, 5'h00, 32'h0,        1'b1, 32'h7FFFFFFF, 8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"rd_cnt7",       1'b0, 5'h07, 32'h0,        1'b1, 32'h00ABCDEF, 8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"wr_cnt1",       1'b1, 5'h01, 32'h00000FFF, 1'b0, 32'h0,        8'h00, 8'h00, 8'h02, 31'hFFF});
        tbl.push_back('{"wr_cnt5_wide",  1'b1, 5'h05, 32'hFFFFFFFF, 1'b0, 32'h0,        8'h00, 8'h00, 8'h20, 31'h7FFFFFFF});
        tbl.push_back('{"wr_clrall",     1'b1, 5'h1F, 32'h0,        1'b0, 32'h0,        8'hFF, 8'hFF, 8'h00, 31'h0});
        tbl.push_back('{"rd_clrall",     1'b0, 5'h1F, 32'h0,        1'b1, 32'h0,        8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"rd_unmap_1b",   1'b0, 5'h1B, 32'h0,        1'b1, 32'h0,        8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"rd_unmap_08",   1'b0, 5'h08, 32'h0,        1'b1, 32'h0,        8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"rd_mask_rst",   1'b0, 5'h1D, 32'h0,        1'b1, 32'h000000FF, 8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"wr_mask",       1'b1, 5'h1D, 32'hFFFFFFDF, 1'b0, 32'h0,        8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"rd_mask",       1'b0, 5'h1D, 32'h0,        1'b1, 32'h000000DF, 8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"rd_carry0",     1'b0, 5'h1C, 32'h0,        1'b1, 32'h0,        8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"rd_ctrl_rst",   1'b0, 5'h1E, 32'h0,        1'b1, 32'h0,        8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"wr_ctrl",       1'b1, 5'h1E, 32'hFFFFFFFF, 1'b0, 32'h0,        8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"rd_ctrl",       1'b0, 5'h1E, 32'h0,        1'b1, RDCLR ? 32'h1 : 32'h0, 8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"rd_cnt2_rdclr", 1'b0, 5'h02, 32'h0,        1'b1, 32'h000002AB, RDCLR ? 8'h04 : 8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"wr_ctrl0",      1'b1, 5'h1E, 32'h0,        1'b0, 32'h0,        8'h00, 8'h00, 8'h00, 31'h0});
        tbl.push_back('{"rd_cnt2_plain", 1'b0, 5'h02, 32'h0,        1'b1, 32'h000002AB, 8'h00, 8'h00, 8'h00, 31'h0});

        foreach (tbl[i]) begin
            txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, o);
            check_txn(tbl[i].name, o, tbl[i].chk_rd, tbl[i].exp_rd,
                      tbl[i].exp_clr, tbl[i].exp_oclr, tbl[i].exp_ld, tbl[i].exp_ldd);
            model_apply(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
        end

        // ---------------- carry / irq sequence (mask = 0xDF) ----------------
        @(posedge clk); #1;
        cnt_ovf = 8'h20;
        @(posedge clk); #1;
        chk("ovf5.irq_same_cycle", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("ovf5.irq_set", 32'(irq), 32'd1);
        cnt_ovf = 8'h00;
        m_carry = m_carry | 8'h20;
        txn(1'b0, 5'h1C, 32'h0, o);
        check_txn("rd_carry20", o, 1'b1, 32'h20, 8'h0, 8'h0, 8'h0, 31'h0);
        txn(1'b1, 5'h1C, 32'h20, o);
        check_txn("w1c_carry20", o, 1'b0, 32'h0, 8'h0, 8'h20, 8'h0, 31'h0);
        chk("w1c_carry20.irq_at_ack", 32'(o.irq_ack), 32'd1);
        chk("w1c_carry20.irq_after", 32'(o.irq_post), 32'd0);
        model_apply(1'b1, 5'h1C, 32'h20);
        txn(1'b0, 5'h1C, 32'h0, o);
        check_txn("rd_carry_clr", o, 1'b1, 32'h0, 8'h0, 8'h0, 8'h0, 31'h0);

        // Overflow on a masked counter sets carry but not irq.
        @(posedge clk); #1;
        cnt_ovf = 8'h01;
        @(posedge clk); #1;
        cnt_ovf = 8'h00;
        m_carry = m_carry | 8'h01;
        repeat (2) @(posedge clk);
        #1;
        chk("masked_ovf.irq", 32'(irq), 32'd0);
        txn(1'b0, 5'h1C, 32'h0, o);
        check_txn("rd_carry01", o, 1'b1, 32'h01, 8'h0, 8'h0, 8'h0, 31'h0);

        // ---------------- reset during CAPT ----------------
        @(posedge clk); #1;
        bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 5'h01; bus.wdata = 32'h55;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_capt.ack", 32'(bus.ack), 32'd0);
        chk("rst_capt.rdata", bus.rdata, 32'h0);
        chk("rst_capt.strobes", 32'({cnt_clr, cnt_ovf_clr, cnt_ld}), 32'h0);
        rst = 1'b0;
        bus.req = 1'b0;
        model_reset();
        strobe_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if ({cnt_clr, cnt_ovf_clr, cnt_ld} != 24'h0 || bus.ack) strobe_seen++;
        end
        chk("rst_capt.no_activity", 32'(strobe_seen), 32'd0);
        txn(1'b0, 5'h1B, 32'h0, o);
        check_txn("rd_1b_after_rst", o, 1'b1, 32'h0, 8'h0, 8'h0, 8'h0, 31'h0);
        txn(1'b0, 5'h1C, 32'h0, o);
        check_txn("rd_carry_after_rst", o, 1'b1, 32'h0, 8'h0, 8'h0, 8'h0, 31'h0);

        // ---------------- randomized transactions vs model ----------------
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < N; i++) cv[i] = 31'($urandom);
            drive_cv();
            if ($urandom_range(0, 2) == 0) begin
                ov = 8'($urandom);
                @(posedge clk); #1;
                cnt_ovf = ov;
                @(posedge clk); #1;
                cnt_ovf = 8'h00;
                m_carry = m_carry | ov;
            end
            w  = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (r < 5)       a = 5'($urandom_range(0, 7));
            else if (r == 5) a = 5'($urandom_range(8, 27));
            else             a = 5'(28 + r - 6);
            wd = $urandom;
            e_rd = model_read(a);
            model_strobes(w, a, wd, e_clr, e_oclr, e_ld, e_ldd);
            txn(w, a, wd, o);
            check_txn($sformatf("rand%0d_%s_%02h", n, w ? "wr" : "rd", a), o, !w, e_rd,
                      e_clr, e_oclr, e_ld, e_ldd);
            model_apply(w, a, wd);
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("rand%0d.irq", n), 32'(irq), 32'(|(m_carry & ~m_mask)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
